// File: rtl/div_bus_sequencer.sv
// Bus-master sequencer for the divider peripheral. It arbitrates two requesters
// round-robin and runs the write/start/poll/read transaction for the granted one.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a request; arbitration and operand latch
// WR_A      | bus write of the dividend
// WR_B      | bus write of the divisor
// WR_INIT   | bus write of the start command
// POLL_RD   | bus read strobe on the status register
// POLL_WAIT | status data returned; check done / poll budget
// RES_RD    | bus read strobe on the result register
// RES_WAIT  | result data returned; capture it
// RESP      | one-cycle ack to the granted requester
module div_bus_sequencer #(
  parameter int         TIMEOUT   = 64,
  parameter logic [4:0] ADDR_A    = 5'h04,
  parameter logic [4:0] ADDR_B    = 5'h08,
  parameter logic [4:0] ADDR_INIT = 5'h0C,
  parameter logic [4:0] ADDR_RES  = 5'h10,
  parameter logic [4:0] ADDR_DONE = 5'h14
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        ack1,
  output logic [31:0] resultado,
  output logic        error,
  output logic        ocupado,
  output logic        habilitar,
  output logic        leer,
  output logic        escribir,
  output logic [4:0]  direccion,
  output logic [15:0] entrada_datos,
  input  logic [31:0] salida_datos
);

  localparam int PW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_INIT, POLL_RD, POLL_WAIT, RES_RD, RES_WAIT, RESP
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     op_a, op_a_nxt, op_b, op_b_nxt;
  logic            gnt, gnt_nxt, last_grant, last_nxt;
  logic [PW-1:0]   poll_cnt, poll_nxt, poll_inc;
  logic [31:0]     res_nxt;
  logic            err_nxt, ack0_nxt, ack1_nxt, busy_nxt;
  logic            hab_nxt, rd_nxt, wr_nxt;
  logic [4:0]      dir_nxt;
  logic [15:0]     din_nxt;
  logic            sel;
  logic [15:0]     a_sel, b_sel;

  assign poll_inc = poll_cnt + PW'(1);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_a          <= '0;
      op_b          <= '0;
      gnt           <= 1'b0;
      last_grant    <= 1'b1;
      poll_cnt      <= '0;
      resultado     <= '0;
      error         <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      ocupado       <= 1'b0;
      habilitar     <= 1'b0;
      leer          <= 1'b0;
      escribir      <= 1'b0;
      direccion     <= '0;
      entrada_datos <= '0;
    end else begin
      state         <= state_nxt;
      op_a          <= op_a_nxt;
      op_b          <= op_b_nxt;
      gnt           <= gnt_nxt;
      last_grant    <= last_nxt;
      poll_cnt      <= poll_nxt;
      resultado     <= res_nxt;
      error         <= err_nxt;
      ack0          <= ack0_nxt;
      ack1          <= ack1_nxt;
      ocupado       <= busy_nxt;
      habilitar     <= hab_nxt;
      leer          <= rd_nxt;
      escribir      <= wr_nxt;
      direccion     <= dir_nxt;
      entrada_datos <= din_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    gnt_nxt   = gnt;
    last_nxt  = last_grant;
    poll_nxt  = poll_cnt;
    res_nxt   = resultado;
    err_nxt   = error;
    sel       = 1'b0;
    a_sel     = a0;
    b_sel     = b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          sel       = (req0 && req1) ? ~last_grant : req1;
          a_sel     = sel ? a1 : a0;
          b_sel     = sel ? b1 : b0;
          gnt_nxt   = sel;
          last_nxt  = sel;
          op_a_nxt  = a_sel;
          op_b_nxt  = b_sel;
          poll_nxt  = '0;
          if (b_sel == 16'h0000) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
            res_nxt   = '0;
          end else begin
            state_nxt = WR_A;
          end
        end
      end
      WR_A:    state_nxt = WR_B;
      WR_B:    state_nxt = WR_INIT;
      WR_INIT: state_nxt = POLL_RD;
      POLL_RD: state_nxt = POLL_WAIT;
      POLL_WAIT: begin
        if (salida_datos[0]) begin
          state_nxt = RES_RD;
        end else begin
          poll_nxt = poll_inc;
          if (poll_inc == PW'(TIMEOUT)) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
            res_nxt   = '0;
          end else begin
            state_nxt = POLL_RD;
          end
        end
      end
      RES_RD:  state_nxt = RES_WAIT;
      RES_WAIT: begin
        res_nxt   = salida_datos;
        err_nxt   = 1'b0;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    hab_nxt  = 1'b0;
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    ack0_nxt = 1'b0;
    ack1_nxt = 1'b0;
    dir_nxt  = direccion;
    din_nxt  = entrada_datos;
    busy_nxt = (state_nxt != IDLE);

    case (state_nxt)
      WR_A: begin
        hab_nxt = 1'b1; wr_nxt = 1'b1; dir_nxt = ADDR_A; din_nxt = op_a_nxt;
      end
      WR_B: begin
        hab_nxt = 1'b1; wr_nxt = 1'b1; dir_nxt = ADDR_B; din_nxt = op_b_nxt;
      end
      WR_INIT: begin
        hab_nxt = 1'b1; wr_nxt = 1'b1; dir_nxt = ADDR_INIT; din_nxt = 16'h0001;
      end
      POLL_RD: begin
        hab_nxt = 1'b1; rd_nxt = 1'b1; dir_nxt = ADDR_DONE;
      end
      RES_RD: begin
        hab_nxt = 1'b1; rd_nxt = 1'b1; dir_nxt = ADDR_RES;
      end
      RESP: begin
        ack0_nxt = ~gnt_nxt;
        ack1_nxt = gnt_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_bus_sequencer.sv
// Directed bench for div_bus_sequencer with a small divider-peripheral model
// that answers done after a configurable number of status polls.
module tb_div_bus_sequencer;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        ack0, ack1, error, ocupado, habilitar, leer, escribir;
  logic [31:0] resultado;
  logic [4:0]  direccion;
  logic [15:0] entrada_datos;
  logic [31:0] salida_datos = '0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [4:0]  dir;
    logic [15:0] dat;
  } bus_t;

  bus_t log_q[$];
  int   ack0_cnt = 0, ack1_cnt = 0;
  int   done_after = 1;
  int   m_polls = 0;
  logic [15:0] m_a = '0, m_b = '0;

  div_bus_sequencer #(.TIMEOUT(4)) dut (
    .clock(clock), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .resultado(resultado), .error(error), .ocupado(ocupado),
    .habilitar(habilitar), .leer(leer), .escribir(escribir),
    .direccion(direccion), .entrada_datos(entrada_datos),
    .salida_datos(salida_datos)
  );

  always #5 clock = ~clock;

  // Divider peripheral model: read data appears the cycle after the strobe.
  always @(posedge clock) begin
    if (habilitar && escribir) begin
      case (direccion)
        5'h04:   m_a <= entrada_datos;
        5'h08:   m_b <= entrada_datos;
        5'h0C:   m_polls <= 0;
        default: ;
      endcase
    end
    if (habilitar && leer) begin
      if (direccion == 5'h14) begin
        m_polls <= m_polls + 1;
        salida_datos <= (done_after != 0 && m_polls + 1 >= done_after) ? 32'd1 : 32'd0;
      end else if (direccion == 5'h10) begin
        salida_datos <= (m_b != 16'h0) ? {16'h0, m_a / m_b} : 32'd0;
      end
    end
  end

  always @(negedge clock) begin
    if (habilitar) log_q.push_back('{leer, escribir, direccion, entrada_datos});
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
  end

  task automatic clear_log();
    log_q.delete();
    ack0_cnt = 0;
    ack1_cnt = 0;
  endtask

  task automatic wait_ack(input int limit, output int cyc, output bit seen);
    cyc = 0;
    seen = 1'b0;
    while (cyc < limit && !seen) begin
      @(negedge clock);
      cyc++;
      if (ack0 || ack1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ack0, ack1, resultado, error, ocupado, habilitar, leer, escribir, direccion, entrada_datos} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b%b res=%h err=%b busy=%b hab=%b rd=%b wr=%b dir=%h din=%h, want all 0",
               ack0, ack1, resultado, error, ocupado, habilitar, leer, escribir, direccion, entrada_datos);
    end
    repeat (2) @(negedge clock);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bus_t exp_q[6];
    int   cyc;
    bit   seen;
    exp_q = '{'{1'b0, 1'b1, 5'h04, 16'h0064}, '{1'b0, 1'b1, 5'h08, 16'h0004},
              '{1'b0, 1'b1, 5'h0C, 16'h0001}, '{1'b1, 1'b0, 5'h14, 16'h0001},
              '{1'b1, 1'b0, 5'h14, 16'h0001}, '{1'b1, 1'b0, 5'h10, 16'h0001}};
    done_after = 2;
    @(negedge clock);
    clear_log();
    a0 = 16'h0064; b0 = 16'h0004; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    wait_ack(30, cyc, seen);
    n_cmp++;
    if (!seen || cyc + 1 != 10) begin
      n_err++;
      $display("FAIL basic_latency: got seen=%0b cycles=%0d, want ack 10 cycles after req", seen, cyc + 1);
    end
    n_cmp++;
    if (resultado !== 32'h19 || error !== 1'b0 || ack0 !== 1'b1) begin
      n_err++;
      $display("FAIL basic_result: got res=%h err=%b ack0=%b, want 00000019 0 1", resultado, error, ack0);
    end
    @(negedge clock);
    n_cmp++;
    if (ack0 !== 1'b0 || ack0_cnt != 1 || ack1_cnt != 0) begin
      n_err++;
      $display("FAIL basic_ack_pulse: got ack0=%b ack0_cnt=%0d ack1_cnt=%0d, want 0 1 0", ack0, ack0_cnt, ack1_cnt);
    end
    n_cmp++;
    if (log_q.size() != 6) begin
      n_err++;
      $display("FAIL basic_bus_count: got %0d bus cycles, want 6", log_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (log_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL basic_bus[%0d]: got %h, want %h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_operand_change();
    int cyc;
    bit seen;
    done_after = 1;
    @(negedge clock);
    clear_log();
    a0 = 16'h0064; b0 = 16'h0004; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0; a0 = 16'h1234; b0 = 16'h0002;
    wait_ack(30, cyc, seen);
    n_cmp++;
    if (!seen || log_q.size() < 2) begin
      n_err++;
      $display("FAIL opchg_ack: got seen=%0b bus_cycles=%0d, want ack and >=2 bus cycles", seen, log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].dat !== 16'h0064 || log_q[1].dat !== 16'h0004) begin
        n_err++;
        $display("FAIL opchg_latched: got a=%h b=%h, want 0064 0004", log_q[0].dat, log_q[1].dat);
      end
      n_cmp++;
      if (resultado !== 32'h19) begin
        n_err++;
        $display("FAIL opchg_result: got %h, want 00000019", resultado);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int cyc, n_done, n_res;
    bit seen;
    done_after = 0;
    @(negedge clock);
    clear_log();
    a0 = 16'h0008; b0 = 16'h0002; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    wait_ack(40, cyc, seen);
    n_cmp++;
    if (!seen || cyc + 1 != 12 || ack0 !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_latency: got seen=%0b cycles=%0d ack0=%b, want ack0 12 cycles after req", seen, cyc + 1, ack0);
    end
    n_cmp++;
    if (error !== 1'b1 || resultado !== 32'h0) begin
      n_err++;
      $display("FAIL timeout_error: got err=%b res=%h, want 1 00000000", error, resultado);
    end
    n_done = 0;
    n_res = 0;
    foreach (log_q[i]) begin
      if (log_q[i].rd && log_q[i].dir == 5'h14) n_done++;
      if (log_q[i].rd && log_q[i].dir == 5'h10) n_res++;
    end
    n_cmp++;
    if (n_done != 4 || n_res != 0) begin
      n_err++;
      $display("FAIL timeout_polls: got %0d status reads %0d result reads, want 4 0", n_done, n_res);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic        exp_who[4];
    logic [31:0] exp_res[4];
    int cyc;
    bit seen;
    exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_res = '{32'd3, 32'd10, 32'd3, 32'd10};
    done_after = 1;
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    a0 = 16'd9; b0 = 16'd3; a1 = 16'd50; b1 = 16'd5;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(30, cyc, seen);
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      n_cmp++;
      if (!seen || ack1 !== exp_who[k] || ack0 !== ~exp_who[k] || resultado !== exp_res[k] || error !== 1'b0) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got seen=%0b ack0=%b ack1=%b res=%0d err=%b, want ack%0d res=%0d err=0",
                 k, seen, ack0, ack1, resultado, error, exp_who[k], exp_res[k]);
      end
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL rr_idle: got ocupado=%b, want 0", ocupado);
    end
  endtask

  task automatic test_div0();
    int cyc;
    bit seen;
    @(negedge clock);
    clear_log();
    a1 = 16'd7; b1 = 16'd0; req1 = 1'b1;
    wait_ack(5, cyc, seen);
    req1 = 1'b0;
    n_cmp++;
    if (!seen || cyc != 1 || ack1 !== 1'b1) begin
      n_err++;
      $display("FAIL div0_latency: got seen=%0b cycles=%0d ack1=%b, want ack1 in the cycle after grant", seen, cyc, ack1);
    end
    n_cmp++;
    if (error !== 1'b1 || resultado !== 32'h0) begin
      n_err++;
      $display("FAIL div0_error: got err=%b res=%h, want 1 00000000", error, resultado);
    end
    repeat (2) @(negedge clock);
    n_cmp++;
    if (log_q.size() != 0 || ack1_cnt != 1 || ack0_cnt != 0) begin
      n_err++;
      $display("FAIL div0_nobus: got bus_cycles=%0d ack1_cnt=%0d ack0_cnt=%0d, want 0 1 0", log_q.size(), ack1_cnt, ack0_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    done_after = 0;
    @(negedge clock);
    a0 = 16'd20; b0 = 16'd4; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    cyc = 0;
    while (cyc < 20 && !(leer && direccion == 5'h14)) begin
      @(negedge clock);
      cyc++;
    end
    @(posedge clock);
    #2;
    n_cmp++;
    if (ocupado !== 1'b1 || direccion !== 5'h14 || habilitar !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_pre: got busy=%b dir=%h hab=%b, want 1 14 0", ocupado, direccion, habilitar);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({habilitar, leer, escribir, ocupado} !== 4'b0 || direccion !== 5'h0) begin
      n_err++;
      $display("FAIL rstmid_drop: got hab=%b rd=%b wr=%b busy=%b dir=%h, want all 0",
               habilitar, leer, escribir, ocupado, direccion);
    end
    @(negedge clock);
    rst = 1'b1;
    done_after = 1;
    @(negedge clock);
    a0 = 16'h0030; b0 = 16'h0003; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    wait_ack(30, cyc, seen);
    n_cmp++;
    if (!seen || cyc + 1 != 8 || ack0 !== 1'b1 || resultado !== 32'h10 || error !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_recover: got seen=%0b cycles=%0d ack0=%b res=%h err=%b, want 8 1 00000010 0",
               seen, cyc + 1, ack0, resultado, error);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand_change();
    test_timeout();
    test_back_to_back();
    test_div0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
